// File: rtl/umq_match_wc_if.sv
// ---------------------------------------------------------------------------
// umq_match_wc_if
//   Bundle of the unexpected-message-queue signals between the network
//   packetizer (insert side), the receive-request engine (find side) and the
//   queue itself.
//
//   Insert  : ins_valid / ins_ready, ins_comm, ins_src, ins_tag, ins_payload
//   Find    : req_valid / req_ready, req_comm, req_src, req_tag
//             (all-ones req_src = ANY_SOURCE, all-ones req_tag = ANY_TAG)
//   Result  : resp_valid (one-cycle strobe), resp_found, resp_src, resp_tag,
//             resp_payload
//   Status  : count, q_full, q_empty
//
//   modport master : the side driving inserts and requests
//   modport slave  : the queue
// ---------------------------------------------------------------------------
interface umq_match_wc_if #(
    parameter int DEPTH         = 16,
    parameter int COMM_BIT      = 4,
    parameter int RANK_BIT      = 8,
    parameter int TAG_BIT       = 8,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int CNT_W         = $clog2(DEPTH + 1)
);
    logic                     ins_valid;
    logic                     ins_ready;
    logic [COMM_BIT-1:0]      ins_comm;
    logic [RANK_BIT-1:0]      ins_src;
    logic [TAG_BIT-1:0]       ins_tag;
    logic [PAYLOAD_WIDTH-1:0] ins_payload;

    logic                     req_valid;
    logic                     req_ready;
    logic [COMM_BIT-1:0]      req_comm;
    logic [RANK_BIT-1:0]      req_src;
    logic [TAG_BIT-1:0]       req_tag;

    logic                     resp_valid;
    logic                     resp_found;
    logic [RANK_BIT-1:0]      resp_src;
    logic [TAG_BIT-1:0]       resp_tag;
    logic [PAYLOAD_WIDTH-1:0] resp_payload;

    logic [CNT_W-1:0]         count;
    logic                     q_full;
    logic                     q_empty;

    modport master (
        output ins_valid, ins_comm, ins_src, ins_tag, ins_payload,
        output req_valid, req_comm, req_src, req_tag,
        input  ins_ready, req_ready,
        input  resp_valid, resp_found, resp_src, resp_tag, resp_payload,
        input  count, q_full, q_empty
    );

    modport slave (
        input  ins_valid, ins_comm, ins_src, ins_tag, ins_payload,
        input  req_valid, req_comm, req_src, req_tag,
        output ins_ready, req_ready,
        output resp_valid, resp_found, resp_src, resp_tag, resp_payload,
        output count, q_full, q_empty
    );
endinterface

// File: rtl/umq_match_wc.sv
// ---------------------------------------------------------------------------
// umq_match_wc
//   Unexpected-message queue with wildcard matching. Holds up to DEPTH
//   headers in arrival order (slot 0 = oldest). A find request searches all
//   valid slots for (comm, src, tag), where an all-ones src or tag matches
//   anything; the oldest hit is returned and removed, and the younger
//   entries shift down one slot so arrival order is kept.
//
//   Ports
//     clk : rising-edge clock
//     rst : asynchronous active-low reset
//     bus : umq_match_wc_if.slave (insert, find, result and status signals)
//
//   Find timing: request accepted at edge T, MATCH during T..T+1, resp_valid
//   during T+1..T+2, back to IDLE afterwards.
// ---------------------------------------------------------------------------
module umq_match_wc #(
    parameter int DEPTH         = 16,
    parameter int COMM_BIT      = 4,
    parameter int RANK_BIT      = 8,
    parameter int TAG_BIT       = 8,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    umq_match_wc_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [RANK_BIT-1:0] ANY_SOURCE = '1;
    localparam logic [TAG_BIT-1:0]  ANY_TAG    = '1;
    localparam logic [CNT_W-1:0]    DEPTH_CNT  = CNT_W'(DEPTH);

    typedef struct packed {
        logic [COMM_BIT-1:0]      comm;
        logic [RANK_BIT-1:0]      src;
        logic [TAG_BIT-1:0]       tag;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;

    entry_t                   slots [DEPTH];
    logic [CNT_W-1:0]         count_q;

    logic [COMM_BIT-1:0]      key_comm;
    logic [RANK_BIT-1:0]      key_src;
    logic [TAG_BIT-1:0]       key_tag;

    logic                     resp_found_q;
    logic [RANK_BIT-1:0]      resp_src_q;
    logic [TAG_BIT-1:0]       resp_tag_q;
    logic [PAYLOAD_WIDTH-1:0] resp_payload_q;

    logic [DEPTH-1:0]         hit_vec;
    logic                     hit;
    logic [IDX_W-1:0]         hit_idx;
    logic                     remove;
    logic                     ins_ready;
    logic                     ins_fire;
    logic [CNT_W-1:0]         wr_ptr;
    entry_t                   ins_entry;

    // ------------------------------------------------------------------
    // Match vector: only slots below count take part, so stale contents
    // beyond the tail can never produce a hit.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = (CNT_W'(i) < count_q)
                      && (slots[i].comm == key_comm)
                      && ((key_src == ANY_SOURCE) || (slots[i].src == key_src))
                      && ((key_tag == ANY_TAG)    || (slots[i].tag == key_tag));
        end
    end

    // Lowest index wins: scanning downwards lets the oldest hit overwrite
    // any younger one.
    // NOTE: every variable of an always_comb gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign remove    = (state == MATCH) && hit;
    assign ins_ready = (count_q < DEPTH_CNT);
    assign ins_fire  = bus.ins_valid && ins_ready;
    // With a removal on the same edge, the tail moves down one slot.
    assign wr_ptr    = remove ? (count_q - CNT_W'(1)) : count_q;
    assign ins_entry = '{comm:    bus.ins_comm,
                         src:     bus.ins_src,
                         tag:     bus.ins_tag,
                         payload: bus.ins_payload};

    // ------------------------------------------------------------------
    // Slot storage. Shift-down on removal, then tail write on insert; the
    // insert is the later non-blocking assignment, so when both target the
    // same slot the new entry wins.
    // NOTE: the slot array has no reset; slots at or beyond count are never
    // compared or returned, so clearing count is enough to empty the queue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (remove) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= hit_idx) begin
                    slots[i] <= slots[i + 1];
                end
            end
        end
        if (ins_fire) begin
            slots[wr_ptr[IDX_W-1:0]] <= ins_entry;
        end
    end

    // Occupancy: simultaneous insert and removal leaves count unchanged.
    // NOTE: sequential state is always written with non-blocking
    // assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            case ({ins_fire, remove})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Find FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = bus.req_valid ? MATCH : IDLE;
            MATCH:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Key latch on acceptance, result capture at the edge that ends MATCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_comm       <= '0;
            key_src        <= '0;
            key_tag        <= '0;
            resp_found_q   <= 1'b0;
            resp_src_q     <= '0;
            resp_tag_q     <= '0;
            resp_payload_q <= '0;
        end else begin
            if ((state == IDLE) && bus.req_valid) begin
                key_comm <= bus.req_comm;
                key_src  <= bus.req_src;
                key_tag  <= bus.req_tag;
            end
            if (state == MATCH) begin
                resp_found_q   <= hit;
                resp_src_q     <= hit ? slots[hit_idx].src     : '0;
                resp_tag_q     <= hit ? slots[hit_idx].tag     : '0;
                resp_payload_q <= hit ? slots[hit_idx].payload : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ins_ready    = ins_ready;
    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = (state == RESP);
    assign bus.resp_found   = resp_found_q;
    assign bus.resp_src     = resp_src_q;
    assign bus.resp_tag     = resp_tag_q;
    assign bus.resp_payload = resp_payload_q;
    assign bus.count        = count_q;
    assign bus.q_full       = (count_q == DEPTH_CNT);
    assign bus.q_empty      = (count_q == '0);

endmodule

// File: tb/tb_umq_match_wc.sv
// ---------------------------------------------------------------------------
// tb_umq_match_wc
//   Self-checking bench for umq_match_wc. A queue-based reference model
//   tracks the expected contents and find results; a compare process checks
//   every DUT output against it on each falling edge. Directed scenarios add
//   literal expectations, followed by a randomized insert/find phase.
// ---------------------------------------------------------------------------
module tb_umq_match_wc;
    localparam int DEPTH         = 16;
    localparam int COMM_BIT      = 4;
    localparam int RANK_BIT      = 8;
    localparam int TAG_BIT       = 8;
    localparam int PAYLOAD_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    umq_match_wc_if #(
        .DEPTH(DEPTH), .COMM_BIT(COMM_BIT), .RANK_BIT(RANK_BIT),
        .TAG_BIT(TAG_BIT), .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .CNT_W(CNT_W)
    ) bus ();

    umq_match_wc #(
        .DEPTH(DEPTH), .COMM_BIT(COMM_BIT), .RANK_BIT(RANK_BIT),
        .TAG_BIT(TAG_BIT), .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the queue contents as an ordered list, plus the
    // phase of the current find (0 idle, 1 matching, 2 responding).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  comm;
        logic [7:0]  src;
        logic [7:0]  tag;
        logic [31:0] pay;
    } ent_t;

    ent_t       mq[$];
    int         ph = 0;
    logic [3:0] m_comm;
    logic [7:0] m_src;
    logic [7:0] m_tag;
    logic       m_found = 1'b0;
    ent_t       m_resp  = '0;
    bit         m_ins_fire;
    ent_t       m_new;
    int         m_hit_k;

    function automatic bit key_hit(input ent_t e, input logic [3:0] c,
                                   input logic [7:0] s, input logic [7:0] t);
        return (e.comm == c) && (s == 8'hFF || e.src == s) && (t == 8'hFF || e.tag == t);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            ph      = 0;
            m_found = 1'b0;
            m_resp  = '0;
        end else begin
            m_ins_fire = bus.ins_valid && (mq.size() < DEPTH);
            m_new      = '{comm: bus.ins_comm, src: bus.ins_src,
                           tag: bus.ins_tag, pay: bus.ins_payload};
            if (ph == 1) begin
                m_hit_k = -1;
                foreach (mq[k]) begin
                    if (m_hit_k < 0 && key_hit(mq[k], m_comm, m_src, m_tag)) m_hit_k = k;
                end
                if (m_hit_k >= 0) begin
                    m_found = 1'b1;
                    m_resp  = mq[m_hit_k];
                    mq.delete(m_hit_k);
                end else begin
                    m_found = 1'b0;
                    m_resp  = '0;
                end
                ph = 2;
            end else if (ph == 2) begin
                ph = 0;
            end else if (bus.req_valid) begin
                m_comm = bus.req_comm;
                m_src  = bus.req_src;
                m_tag  = bus.req_tag;
                ph     = 1;
            end
            // Entries accepted this edge join the tail after any removal.
            if (m_ins_fire) mq.push_back(m_new);
        end
    end

    // Compare process: all outputs against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count",      64'(bus.count),      64'(mq.size()));
            check("m_ins_ready",  64'(bus.ins_ready),  64'(mq.size() < DEPTH));
            check("m_q_full",     64'(bus.q_full),     64'(mq.size() == DEPTH));
            check("m_q_empty",    64'(bus.q_empty),    64'(mq.size() == 0));
            check("m_req_ready",  64'(bus.req_ready),  64'(ph == 0));
            check("m_resp_valid", 64'(bus.resp_valid), 64'(ph == 2));
            if (ph == 2) begin
                check("m_resp_found",   64'(bus.resp_found),   64'(m_found));
                check("m_resp_src",     64'(bus.resp_src),     64'(m_resp.src));
                check("m_resp_tag",     64'(bus.resp_tag),     64'(m_resp.tag));
                check("m_resp_payload", 64'(bus.resp_payload), 64'(m_resp.pay));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (always entered right after a falling edge)
    // ------------------------------------------------------------------
    task automatic do_insert(input logic [3:0] c, input logic [7:0] s,
                             input logic [7:0] t, input logic [31:0] p);
        logic rdy;
        int   n = 0;
        bus.ins_valid   = 1'b1;
        bus.ins_comm    = c;
        bus.ins_src     = s;
        bus.ins_tag     = t;
        bus.ins_payload = p;
        do begin
            rdy = bus.ins_ready;
            @(negedge clk);
            n++;
        end while (!rdy && n < 50);
        bus.ins_valid = 1'b0;
        check("ins_accept", 64'(rdy), 64'(1));
    endtask

    task automatic do_find(input logic [3:0] c, input logic [7:0] s, input logic [7:0] t,
                           input bit with_ins, input logic [31:0] ins_p,
                           output logic found, output logic [7:0] rs,
                           output logic [7:0] rt, output logic [31:0] rp);
        logic rdy;
        int   n = 0;
        bus.req_valid = 1'b1;
        bus.req_comm  = c;
        bus.req_src   = s;
        bus.req_tag   = t;
        do begin
            rdy = bus.req_ready;
            @(negedge clk);
            n++;
        end while (!rdy && n < 50);
        bus.req_valid = 1'b0;
        check("req_accept", 64'(rdy), 64'(1));
        // MATCH cycle: no response yet.
        check("lat_match_rv", 64'(bus.resp_valid), 64'(0));
        if (with_ins) begin
            bus.ins_valid   = 1'b1;
            bus.ins_comm    = 4'd3;
            bus.ins_src     = 8'd1;
            bus.ins_tag     = 8'd1;
            bus.ins_payload = ins_p;
        end
        @(negedge clk);
        if (with_ins) bus.ins_valid = 1'b0;
        check("lat_resp_rv", 64'(bus.resp_valid), 64'(1));
        found = bus.resp_found;
        rs    = bus.resp_src;
        rt    = bus.resp_tag;
        rp    = bus.resp_payload;
        @(negedge clk);
        check("lat_after_rv", 64'(bus.resp_valid), 64'(0));
    endtask

    logic        f;
    logic [7:0]  fs;
    logic [7:0]  ft;
    logic [31:0] fp;
    logic        ins_rdy_q;
    logic        req_rdy_q;
    int          ins_pct;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.ins_valid   = 1'b0;
        bus.ins_comm    = '0;
        bus.ins_src     = '0;
        bus.ins_tag     = '0;
        bus.ins_payload = '0;
        bus.req_valid   = 1'b0;
        bus.req_comm    = '0;
        bus.req_src     = '0;
        bus.req_tag     = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_count",      64'(bus.count),        64'(0));
        check("rst_ins_ready",  64'(bus.ins_ready),    64'(1));
        check("rst_req_ready",  64'(bus.req_ready),    64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid),   64'(0));
        check("rst_resp_found", 64'(bus.resp_found),   64'(0));
        check("rst_resp_pay",   64'(bus.resp_payload), 64'(0));
        check("rst_q_empty",    64'(bus.q_empty),      64'(1));
        check("rst_q_full",     64'(bus.q_full),       64'(0));
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single insert then exact find
        do_insert(4'd1, 8'd5, 8'd7, 32'hA5A5_A5A5);
        check("t1_count1", 64'(bus.count), 64'(1));
        do_find(4'd1, 8'd5, 8'd7, 1'b0, 32'h0, f, fs, ft, fp);
        check("t1_found", 64'(f), 64'(1));
        check("t1_pay",   64'(fp), 64'hA5A5_A5A5);
        check("t1_count0", 64'(bus.count), 64'(0));
        check("t1_empty",  64'(bus.q_empty), 64'(1));

        // ANY_SOURCE returns the oldest hit; exact key finds the later one
        do_insert(4'd1, 8'd3, 8'd9, 32'h1);
        do_insert(4'd1, 8'd4, 8'd9, 32'h11);
        do_insert(4'd1, 8'd3, 8'd9, 32'h2);
        do_find(4'd1, 8'hFF, 8'd9, 1'b0, 32'h0, f, fs, ft, fp);
        check("t2_any_found", 64'(f),  64'(1));
        check("t2_any_src",   64'(fs), 64'(3));
        check("t2_any_pay",   64'(fp), 64'h1);
        do_find(4'd1, 8'd3, 8'd9, 1'b0, 32'h0, f, fs, ft, fp);
        check("t2_exact_pay", 64'(fp), 64'h2);
        do_find(4'd1, 8'hFF, 8'hFF, 1'b0, 32'h0, f, fs, ft, fp);
        check("t2_rem_src", 64'(fs), 64'(4));
        check("t2_rem_pay", 64'(fp), 64'h11);

        // Wrong communicator, then empty queue
        do_insert(4'd1, 8'd5, 8'd7, 32'h77);
        do_find(4'd2, 8'd5, 8'd7, 1'b0, 32'h0, f, fs, ft, fp);
        check("t3_nf_found", 64'(f),  64'(0));
        check("t3_nf_src",   64'(fs), 64'(0));
        check("t3_nf_tag",   64'(ft), 64'(0));
        check("t3_nf_pay",   64'(fp), 64'(0));
        check("t3_nf_count", 64'(bus.count), 64'(1));
        do_find(4'd1, 8'hFF, 8'hFF, 1'b0, 32'h0, f, fs, ft, fp);
        do_find(4'd1, 8'hFF, 8'hFF, 1'b0, 32'h0, f, fs, ft, fp);
        check("t3_empty_found", 64'(f), 64'(0));

        // Fill, hold a 17th insert across a find, then drain in FIFO order
        for (int i = 0; i < DEPTH; i++) begin
            do_insert(4'd0, 8'(i % 4), 8'(i), 32'(i));
        end
        check("t4_full",      64'(bus.q_full),    64'(1));
        check("t4_ins_ready", 64'(bus.ins_ready), 64'(0));
        bus.ins_valid   = 1'b1;
        bus.ins_comm    = 4'd0;
        bus.ins_src     = 8'd0;
        bus.ins_tag     = 8'd0;
        bus.ins_payload = 32'd100;
        do_find(4'd0, 8'hFF, 8'hFF, 1'b0, 32'h0, f, fs, ft, fp);
        bus.ins_valid = 1'b0;
        check("t4_first_pay", 64'(fp), 64'(0));
        check("t4_count16",   64'(bus.count), 64'(16));
        for (int i = 1; i <= DEPTH; i++) begin
            do_find(4'd0, 8'hFF, 8'hFF, 1'b0, 32'h0, f, fs, ft, fp);
            check("t4_drain_pay", 64'(fp), (i == DEPTH) ? 64'd100 : 64'(i));
        end
        check("t4_empty", 64'(bus.q_empty), 64'(1));

        // Insert on the same edge as removal of slot 0 with count 3
        do_insert(4'd3, 8'd1, 8'd1, 32'h31);
        do_insert(4'd3, 8'd1, 8'd1, 32'h32);
        do_insert(4'd3, 8'd1, 8'd1, 32'h33);
        do_find(4'd3, 8'd1, 8'd1, 1'b1, 32'h34, f, fs, ft, fp);
        check("t5_pay",   64'(fp), 64'h31);
        check("t5_count", 64'(bus.count), 64'(3));
        for (int i = 0; i < 3; i++) begin
            do_find(4'd3, 8'hFF, 8'hFF, 1'b0, 32'h0, f, fs, ft, fp);
            check("t5_drain_pay", 64'(fp), 64'(32'h32 + i));
        end

        // Reset during MATCH aborts the find
        do_insert(4'd1, 8'd5, 8'd7, 32'h99);
        bus.req_valid = 1'b1;
        bus.req_comm  = 4'd1;
        bus.req_src   = 8'd5;
        bus.req_tag   = 8'd7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_resp", 64'(bus.resp_valid), 64'(0));
        end
        rst = 1'b1;
        @(negedge clk);
        check("t6_count", 64'(bus.count),   64'(0));
        check("t6_empty", 64'(bus.q_empty), 64'(1));
        do_find(4'd1, 8'd5, 8'd7, 1'b0, 32'h0, f, fs, ft, fp);
        check("t6_found", 64'(f), 64'(0));

        // Randomized traffic: a fill-heavy half then a drain-heavy half
        ins_rdy_q = bus.ins_ready;
        req_rdy_q = bus.req_ready;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ins_pct = (cyc < 1500) ? 60 : 15;
            if (!(bus.ins_valid && !ins_rdy_q)) begin
                if ($urandom_range(99) < ins_pct) begin
                    bus.ins_valid   = 1'b1;
                    bus.ins_comm    = 4'($urandom_range(1));
                    bus.ins_src     = 8'($urandom_range(3));
                    bus.ins_tag     = 8'($urandom_range(3));
                    bus.ins_payload = $urandom;
                end else begin
                    bus.ins_valid = 1'b0;
                end
            end
            if (!(bus.req_valid && !req_rdy_q)) begin
                if ($urandom_range(99) < 40) begin
                    bus.req_valid = 1'b1;
                    bus.req_comm  = 4'($urandom_range(1));
                    bus.req_src   = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(3));
                    bus.req_tag   = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(3));
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            ins_rdy_q = bus.ins_ready;
            req_rdy_q = bus.req_ready;
        end
        // Let any held insert or request complete before going quiet.
        @(negedge clk);
        if (ins_rdy_q) bus.ins_valid = 1'b0;
        if (req_rdy_q) bus.req_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ins_ready) bus.ins_valid = 1'b0;
            if (bus.req_ready) bus.req_valid = 1'b0;
        end
        bus.ins_valid = 1'b0;
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
